// File: rtl/adaptive_phase_scheduler_if.sv
// Signal bundle for adaptive_phase_scheduler: vehicle counts and emergency request in,
// lamp, phase and countdown status out.
interface adaptive_phase_scheduler_if;
   logic [3:0] count1;
   logic [3:0] count2;
   logic       emerg_req;
   logic [2:0] main_st;
   logic [2:0] cross_st;
   logic [2:0] phase;
   logic [5:0] sec_left;
   logic       emerg_active;

   modport master (
      output count1, count2, emerg_req,
      input  main_st, cross_st, phase, sec_left, emerg_active
   );

   modport slave (
      input  count1, count2, emerg_req,
      output main_st, cross_st, phase, sec_left, emerg_active
   );
endinterface

// File: rtl/adaptive_phase_scheduler.sv
// Two-street traffic phase scheduler with count-based green time and gap-out.
// Optional main-street emergency preemption is enabled by defining EMERGENCY_PREEMPT_EN.
module adaptive_phase_scheduler #(
   parameter int TICK_DIV    = 50000000,
   parameter int MIN_GREEN   = 5,
   parameter int MAX_GREEN   = 30,
   parameter int SEC_PER_CAR = 2,
   parameter int YELLOW_T    = 3,
   parameter int ALLRED_T    = 1
) (
   input logic                         clk_50MHz,
   input logic                         reset,
   adaptive_phase_scheduler_if.slave   bus
);

   typedef enum logic [2:0] {
      MAIN_GREEN   = 3'd0,
      MAIN_YELLOW  = 3'd1,
      ALLRED_A     = 3'd2,
      CROSS_GREEN  = 3'd3,
      CROSS_YELLOW = 3'd4,
      ALLRED_B     = 3'd5
   } phase_t;

   localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   logic [TW-1:0] tick_cnt;
   logic          tick;

   phase_t        state;
   phase_t        nxt_state;
   logic [5:0]    sec_left_r;
   logic [5:0]    nxt_sec;
   logic [5:0]    elapsed;
   logic [5:0]    nxt_elapsed;
   logic [2:0]    main_st_r;
   logic [2:0]    cross_st_r;
   logic          emerg_active_r;
   logic          nxt_emerg_active;

   logic          emerg_hold;
   logic          emerg_cut;
   logic          in_green;
   logic [3:0]    own_cnt;
   logic [3:0]    opp_cnt;
   logic          gap_out;

   // Wide intermediate so SEC_PER_CAR*15 plus MIN_GREEN never wraps before clamping.
   function automatic logic [5:0] green_dur(input logic [3:0] cnt);
      logic [9:0] raw;
      raw = 10'(MIN_GREEN) + 10'(SEC_PER_CAR) * {6'd0, cnt};
      if (raw < 10'(MIN_GREEN)) raw = 10'(MIN_GREEN);
      if (raw > 10'(MAX_GREEN)) raw = 10'(MAX_GREEN);
      return raw[5:0];
   endfunction

   function automatic logic [2:0] main_lamps(input phase_t p);
      case (p)
         MAIN_GREEN:  return 3'b001;
         MAIN_YELLOW: return 3'b010;
         default:     return 3'b100;
      endcase
   endfunction

   function automatic logic [2:0] cross_lamps(input phase_t p);
      case (p)
         CROSS_GREEN:  return 3'b001;
         CROSS_YELLOW: return 3'b010;
         default:      return 3'b100;
      endcase
   endfunction

   assign tick = (tick_cnt == TW'(TICK_DIV - 1));

   // One-second time base; restarts from zero on reset so the first tick lands TICK_DIV cycles later.
   always_ff @(posedge clk_50MHz) begin
      if (!reset) begin
         tick_cnt <= '0;
      end else if (tick) begin
         tick_cnt <= '0;
      end else begin
         tick_cnt <= tick_cnt + 1'b1;
      end
   end

`ifdef EMERGENCY_PREEMPT_EN
   assign emerg_hold       = bus.emerg_req && (state == MAIN_GREEN);
   assign emerg_cut        = bus.emerg_req && (state == CROSS_GREEN);
   assign nxt_emerg_active = bus.emerg_req &&
                             ((nxt_state == MAIN_GREEN) || (nxt_state == CROSS_GREEN));
`else
   logic unused_emerg_req;
   assign unused_emerg_req = bus.emerg_req;
   assign emerg_hold       = 1'b0;
   assign emerg_cut        = 1'b0;
   assign nxt_emerg_active = 1'b0;
`endif

   // Gap-out: the green street has emptied, the other is waiting, and the minimum green is served.
   always_comb begin
      in_green = (state == MAIN_GREEN) || (state == CROSS_GREEN);
      own_cnt  = (state == MAIN_GREEN) ? bus.count1 : bus.count2;
      opp_cnt  = (state == MAIN_GREEN) ? bus.count2 : bus.count1;
      gap_out  = in_green && !emerg_hold &&
                 (({1'b0, elapsed} + 7'd1) >= 7'(MIN_GREEN)) &&
                 (own_cnt == 4'd0) && (opp_cnt != 4'd0);
   end

   always_comb begin
      nxt_state   = state;
      nxt_sec     = sec_left_r;
      nxt_elapsed = elapsed;
      if (tick && !emerg_hold) begin
         if ((sec_left_r <= 6'd1) || gap_out || emerg_cut) begin
            nxt_elapsed = '0;
            case (state)
               MAIN_GREEN: begin
                  nxt_state = MAIN_YELLOW;
                  nxt_sec   = 6'(YELLOW_T);
               end
               MAIN_YELLOW: begin
                  nxt_state = ALLRED_A;
                  nxt_sec   = 6'(ALLRED_T);
               end
               ALLRED_A: begin
                  nxt_state = CROSS_GREEN;
                  nxt_sec   = green_dur(bus.count2);
               end
               CROSS_GREEN: begin
                  nxt_state = CROSS_YELLOW;
                  nxt_sec   = 6'(YELLOW_T);
               end
               CROSS_YELLOW: begin
                  nxt_state = ALLRED_B;
                  nxt_sec   = 6'(ALLRED_T);
               end
               ALLRED_B: begin
                  nxt_state = MAIN_GREEN;
                  nxt_sec   = green_dur(bus.count1);
               end
               default: begin
                  nxt_state = ALLRED_B;
                  nxt_sec   = 6'(ALLRED_T);
               end
            endcase
         end else begin
            nxt_sec = sec_left_r - 6'd1;
            if (elapsed != 6'h3f) begin
               nxt_elapsed = elapsed + 6'd1;
            end
         end
      end
   end

   // Lamps are decoded from the next state so they change on the same edge as the phase.
   always_ff @(posedge clk_50MHz) begin
      if (!reset) begin
         state          <= ALLRED_B;
         sec_left_r     <= 6'(ALLRED_T);
         elapsed        <= '0;
         main_st_r      <= 3'b100;
         cross_st_r     <= 3'b100;
         emerg_active_r <= 1'b0;
      end else begin
         state          <= nxt_state;
         sec_left_r     <= nxt_sec;
         elapsed        <= nxt_elapsed;
         main_st_r      <= main_lamps(nxt_state);
         cross_st_r     <= cross_lamps(nxt_state);
         emerg_active_r <= nxt_emerg_active;
      end
   end

   assign bus.phase        = state;
   assign bus.sec_left     = sec_left_r;
   assign bus.main_st      = main_st_r;
   assign bus.cross_st     = cross_st_r;
   assign bus.emerg_active = emerg_active_r;

endmodule

// File: tb/tb_adaptive_phase_scheduler.sv
// Table-driven bench for adaptive_phase_scheduler (TICK_DIV=4) with hand sequences for
// gap-out, mid-phase reset, optional emergency preemption and a lamp-safety monitor.
module tb_adaptive_phase_scheduler;

   localparam int TICK_DIV = 4;
   localparam logic [2:0] G = 3'b001;
   localparam logic [2:0] Y = 3'b010;
   localparam logic [2:0] R = 3'b100;

   typedef struct {
      int         ticks;
      logic [3:0] c1;
      logic [3:0] c2;
      logic [2:0] ph;
      logic [5:0] sec;
      logic [2:0] ms;
      logic [2:0] cs;
   } vec_t;

   logic clk_50MHz;
   logic reset;
   int   checks;
   int   errors;
   bit   monitor_on;
   vec_t vecs[21];

   adaptive_phase_scheduler_if bus();

   adaptive_phase_scheduler #(
      .TICK_DIV (TICK_DIV)
   ) dut (
      .clk_50MHz (clk_50MHz),
      .reset     (reset),
      .bus       (bus)
   );

   initial clk_50MHz = 1'b0;
   always #5 clk_50MHz = ~clk_50MHz;

   task automatic checkValue(input string name, input int actual, input int expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   task automatic checkOutput(input string name, input logic [2:0] ph, input logic [5:0] sec,
                              input logic [2:0] ms, input logic [2:0] cs);
      checkValue({name, ".phase"}, int'(bus.phase), int'(ph));
      checkValue({name, ".sec_left"}, int'(bus.sec_left), int'(sec));
      checkValue({name, ".main_st"}, int'(bus.main_st), int'(ms));
      checkValue({name, ".cross_st"}, int'(bus.cross_st), int'(cs));
   endtask

   task automatic stepTicks(input int n);
      repeat (n * TICK_DIV) @(posedge clk_50MHz);
      @(negedge clk_50MHz);
   endtask

   task automatic applyStimulus(input logic [3:0] c1, input logic [3:0] c2, input int ticks);
      bus.count1 = c1;
      bus.count2 = c2;
      stepTicks(ticks);
   endtask

   task automatic doReset(input logic [3:0] c1, input logic [3:0] c2);
      reset      = 1'b0;
      bus.count1 = c1;
      bus.count2 = c2;
      repeat (3) @(posedge clk_50MHz);
      @(negedge clk_50MHz);
   endtask

   // Lamp pattern each phase code must show, plus mutual exclusion of non-red lamps.
   always @(negedge clk_50MHz) begin
      if (monitor_on) begin
         logic [2:0] em;
         logic [2:0] ec;
         case (bus.phase)
            3'd0:    begin em = G; ec = R; end
            3'd1:    begin em = Y; ec = R; end
            3'd3:    begin em = R; ec = G; end
            3'd4:    begin em = R; ec = Y; end
            3'd2,
            3'd5:    begin em = R; ec = R; end
            default: begin em = 3'b000; ec = 3'b000; end
         endcase
         checks++;
         if (!$onehot(bus.main_st) || !$onehot(bus.cross_st) ||
             (bus.main_st != R && bus.cross_st != R) ||
             bus.main_st !== em || bus.cross_st !== ec) begin
            errors++;
            $display("[TB] FAIL lamp_monitor at %0t: phase=%0d main=%b cross=%b, required main=%b cross=%b",
                     $time, bus.phase, bus.main_st, bus.cross_st, em, ec);
         end
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      monitor_on    = 1'b0;
      checks        = 0;
      errors        = 0;
      bus.emerg_req = 1'b0;

      vecs[0]  = '{1,  4'd0,  4'd0,  3'd0, 6'd5,  G, R};
      vecs[1]  = '{1,  4'd0,  4'd0,  3'd0, 6'd4,  G, R};
      vecs[2]  = '{1,  4'd0,  4'd0,  3'd0, 6'd3,  G, R};
      vecs[3]  = '{1,  4'd0,  4'd0,  3'd0, 6'd2,  G, R};
      vecs[4]  = '{1,  4'd0,  4'd0,  3'd0, 6'd1,  G, R};
      vecs[5]  = '{1,  4'd0,  4'd0,  3'd1, 6'd3,  Y, R};
      vecs[6]  = '{1,  4'd0,  4'd0,  3'd1, 6'd2,  Y, R};
      vecs[7]  = '{1,  4'd0,  4'd0,  3'd1, 6'd1,  Y, R};
      vecs[8]  = '{1,  4'd0,  4'd0,  3'd2, 6'd1,  R, R};
      vecs[9]  = '{1,  4'd0,  4'd7,  3'd3, 6'd19, R, G};
      vecs[10] = '{18, 4'd0,  4'd7,  3'd3, 6'd1,  R, G};
      vecs[11] = '{1,  4'd0,  4'd7,  3'd4, 6'd3,  R, Y};
      vecs[12] = '{3,  4'd0,  4'd7,  3'd5, 6'd1,  R, R};
      vecs[13] = '{1,  4'd15, 4'd15, 3'd0, 6'd30, G, R};
      vecs[14] = '{29, 4'd15, 4'd15, 3'd0, 6'd1,  G, R};
      vecs[15] = '{1,  4'd15, 4'd15, 3'd1, 6'd3,  Y, R};
      vecs[16] = '{2,  4'd15, 4'd15, 3'd1, 6'd1,  Y, R};
      vecs[17] = '{1,  4'd15, 4'd15, 3'd2, 6'd1,  R, R};
      vecs[18] = '{1,  4'd15, 4'd15, 3'd3, 6'd30, R, G};
      vecs[19] = '{30, 4'd15, 4'd15, 3'd4, 6'd3,  R, Y};
      vecs[20] = '{4,  4'd3,  4'd15, 3'd0, 6'd11, G, R};

      // Reset state, then the table walks a full cycle from release.
      doReset(4'd0, 4'd0);
      monitor_on = 1'b1;
      checkOutput("reset", 3'd5, 6'd1, R, R);
      checkValue("reset.emerg_active", int'(bus.emerg_active), 0);
      reset = 1'b1;
      for (int i = 0; i < 21; i++) begin
         applyStimulus(vecs[i].c1, vecs[i].c2, vecs[i].ticks);
         checkOutput($sformatf("vec%0d", i), vecs[i].ph, vecs[i].sec, vecs[i].ms, vecs[i].cs);
      end

      // Gap-out: long main green, main empties while cross waits.
      doReset(4'd10, 4'd0);
      reset = 1'b1;
      applyStimulus(4'd10, 4'd0, 1);
      checkOutput("gap.entry", 3'd0, 6'd25, G, R);
      applyStimulus(4'd0, 4'd3, 1);
      checkOutput("gap.no_reload", 3'd0, 6'd24, G, R);
      applyStimulus(4'd0, 4'd3, 3);
      checkOutput("gap.elapsed4", 3'd0, 6'd21, G, R);
      applyStimulus(4'd0, 4'd3, 1);
      checkOutput("gap.yellow", 3'd1, 6'd3, Y, R);
      applyStimulus(4'd0, 4'd3, 3);
      checkOutput("gap.allred_a", 3'd2, 6'd1, R, R);
      applyStimulus(4'd0, 4'd3, 1);
      checkOutput("gap.cross_green", 3'd3, 6'd11, R, G);
      applyStimulus(4'd0, 4'd3, 11);
      checkOutput("gap.cross_yellow", 3'd4, 6'd3, R, Y);
      applyStimulus(4'd0, 4'd3, 1);
      checkOutput("gap.cross_yellow2", 3'd4, 6'd2, R, Y);

      // Reset during cross yellow aborts straight to all-red.
      reset = 1'b0;
      @(posedge clk_50MHz);
      @(negedge clk_50MHz);
      checkOutput("midreset", 3'd5, 6'd1, R, R);
      checkValue("midreset.emerg_active", int'(bus.emerg_active), 0);
      reset = 1'b1;
      repeat (3) @(posedge clk_50MHz);
      @(negedge clk_50MHz);
      checkOutput("midreset.allred_hold", 3'd5, 6'd1, R, R);
      @(posedge clk_50MHz);
      @(negedge clk_50MHz);
      checkOutput("midreset.main_green", 3'd0, 6'd5, G, R);

      applyStimulus(4'd0, 4'd3, 5);
      checkOutput("emerg.pre_yellow", 3'd1, 6'd3, Y, R);
      applyStimulus(4'd0, 4'd3, 4);
      checkOutput("emerg.pre_cross", 3'd3, 6'd11, R, G);
      bus.emerg_req = 1'b1;
      repeat (TICK_DIV - 1) @(posedge clk_50MHz);
      @(negedge clk_50MHz);
`ifdef EMERGENCY_PREEMPT_EN
      checkValue("emerg.active_cross", int'(bus.emerg_active), 1);
      checkOutput("emerg.cross_hold", 3'd3, 6'd11, R, G);
      stepTicks(1);
      checkOutput("emerg.cross_cut", 3'd4, 6'd3, R, Y);
      stepTicks(4);
      checkOutput("emerg.main_green", 3'd0, 6'd5, G, R);
      checkValue("emerg.active_main", int'(bus.emerg_active), 1);
      stepTicks(3);
      checkOutput("emerg.main_frozen", 3'd0, 6'd5, G, R);
      checkValue("emerg.active_frozen", int'(bus.emerg_active), 1);
      bus.emerg_req = 1'b0;
      stepTicks(1);
      checkOutput("emerg.resume", 3'd0, 6'd4, G, R);
      checkValue("emerg.active_release", int'(bus.emerg_active), 0);
`else
      checkValue("emerg.ignored_active", int'(bus.emerg_active), 0);
      stepTicks(1);
      checkOutput("emerg.ignored_cross", 3'd3, 6'd10, R, G);
      stepTicks(1);
      checkOutput("emerg.ignored_cross2", 3'd3, 6'd9, R, G);
      checkValue("emerg.ignored_active2", int'(bus.emerg_active), 0);
      bus.emerg_req = 1'b0;
`endif

      // Random counts and requests; the lamp monitor carries the checking here.
      for (int k = 0; k < 60; k++) begin
         bus.emerg_req = ($urandom_range(0, 3) == 0);
         applyStimulus(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1);
      end
      bus.emerg_req = 1'b0;

      monitor_on = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
